// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types, activation encodings, default weights and saturation helper.
package neuron_pkg;
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_DONE} state_e;
  localparam int ACT_RELU  = 0;
  localparam int ACT_IDENT = 1;
  localparam int ACT_LEAKY = 2;
  localparam int DEF_W [4] = '{5, -5, 12, 14};
  function automatic int def_weight(input int n, input int i);
    return (n == 4 && i < 4) ? DEF_W[i] : 0;
  endfunction
  // returns {above max, below min} for a dw-bit signed target
  function automatic logic [1:0] sat_range(input longint v, input int dw);
    longint mx;
    mx = (longint'(1) << (dw - 1)) - 1;
    return {v > mx, v < -mx - 1};
  endfunction
endpackage

// File: rtl/neuron_sat_act.sv
// neuron_sat_act: activation followed by saturation from accumulator width to output width.
module neuron_sat_act
  import neuron_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 19,
  parameter int ACT_MODE   = 0,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  output logic signed [DATA_WIDTH-1:0] y_o,
  output logic                         sat_o
);
  localparam logic signed [DATA_WIDTH-1:0] MAXV = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH-1:0] leak;
  logic signed [ACC_WIDTH-1:0] act;
  logic [1:0] rng;
  assign leak = acc_i >>> LEAK_SHIFT;
  always_comb begin
    act = acc_i;
    if (acc_i[ACC_WIDTH-1])
      act = (ACT_MODE == ACT_RELU) ? '0 : (ACT_MODE == ACT_LEAKY) ? leak : acc_i;
    rng = sat_range(longint'(act), DATA_WIDTH);
    y_o = rng[1] ? MAXV : rng[0] ? MINV : act[DATA_WIDTH-1:0];
    sat_o = |rng;
  end
endmodule

// File: rtl/neuron_param.sv
// neuron_param: single-multiplier time-shared neuron (MAC over N inputs, bias, activation, saturation).
module neuron_param
  import neuron_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int N_INPUTS   = 4,
  parameter int ACT_MODE   = 0,
  parameter int LEAK_SHIFT = 3,
  parameter int BIAS       = -5,
  localparam int AW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] x_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DATA_WIDTH-1:0]   y,
  output logic                           sat,
  input  logic                           w_we,
  input  logic [AW-1:0]                  w_addr,
  input  logic signed [DATA_WIDTH-1:0]   w_data
);
  localparam int IW = $clog2(N_INPUTS + 1);
  localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(N_INPUTS) + 1;
  localparam logic signed [ACC_WIDTH-1:0] BIAS_ACC = ACC_WIDTH'(BIAS);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [2*DATA_WIDTH-1:0] prod_q, prod_d, full;
  logic signed [DATA_WIDTH-1:0] x_q [N_INPUTS];
  logic signed [DATA_WIDTH-1:0] w_q [N_INPUTS];
  logic signed [DATA_WIDTH-1:0] y_q, y_act;
  logic sat_q, sat_act, accept, last;
  logic [AW-1:0] idx_m;
  assign in_ready = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign y = y_q;
  assign sat = sat_q;
  assign accept = in_ready && in_valid;
  assign last = 32'(idx_q) == N_INPUTS;
  assign idx_m = AW'(idx_q);
  assign full = x_q[idx_m] * w_q[idx_m];
  // The product is registered, so the accumulator trails the index by one cycle
  // and MAC runs N_INPUTS+1 cycles to drain the last product.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    acc_d = acc_q;
    prod_d = prod_q;
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_MAC;
        idx_d = '0;
        acc_d = BIAS_ACC;
      end
      S_MAC: begin
        prod_d = full >>> FRAC_BITS;
        acc_d = (idx_q != '0) ? acc_q + ACC_WIDTH'(prod_q) : acc_q;
        idx_d = last ? '0 : idx_q + 1'b1;
        state_d = last ? S_ACT : S_MAC;
      end
      S_ACT: state_d = S_DONE;
      S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      acc_q <= '0;
      prod_q <= '0;
      y_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      prod_q <= prod_d;
      if (state_q == S_ACT) begin
        y_q <= y_act;
        sat_q <= sat_act;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        x_q[i] <= '0;
        w_q[i] <= DATA_WIDTH'(def_weight(N_INPUTS, i));
      end
    end else begin
      if (accept)
        for (int i = 0; i < N_INPUTS; i++) x_q[i] <= x_in[i*DATA_WIDTH +: DATA_WIDTH];
      if (state_q == S_IDLE && w_we && 32'(w_addr) < N_INPUTS)
        w_q[w_addr] <= w_data;
    end
  end
  neuron_sat_act #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .ACT_MODE(ACT_MODE),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_sat_act (
    .acc_i(acc_q),
    .y_o(y_act),
    .sat_o(sat_act)
  );
endmodule

// File: tb/tb_neuron_param.sv
// tb_neuron_param: three neurons (ReLU, identity, leaky) driven in lockstep against an arithmetic model.
module tb_neuron_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] x_in = '0;
  logic w_we = 1'b0;
  logic [1:0] w_addr = '0;
  logic [7:0] w_data = '0;
  logic ir [3];
  logic ov [3];
  logic [7:0] yv [3];
  logic sv [3];
  int total = 0;
  int fails = 0;
  int wm [4] = '{5, -5, 12, 14};
  int xs [4];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    neuron_param #(.ACT_MODE(g)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]), .x_in(x_in),
      .out_valid(ov[g]), .out_ready(out_ready), .y(yv[g]), .sat(sv[g]),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data)
    );
  end
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int model(input int m, output int s);
    int acc = -5;
    for (int i = 0; i < 4; i++) acc += (xs[i] * wm[i]) >>> 4;
    if (acc < 0 && m == 0) acc = 0;
    if (acc < 0 && m == 2) acc = acc >>> 3;
    s = (acc > 127 || acc < -128) ? 1 : 0;
    return acc > 127 ? 127 : acc < -128 ? -128 : acc;
  endfunction
  function automatic int sx(input logic [7:0] b);
    return int'($signed(b));
  endfunction
  task automatic set_x(input int a, input int b, input int c, input int d);
    logic [7:0] t [4];
    xs = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      t[i] = 8'(xs[i]);
      x_in[i*8 +: 8] = t[i];
    end
  endtask
  task automatic wr(input int a, input int d);
    @(negedge clk);
    w_we = 1'b1; w_addr = 2'(a); w_data = 8'(d);
    @(posedge clk);
    #1 w_we = 1'b0;
    wm[a] = sx(8'(d));
  endtask
  // wmode: 0 none, 1 write attempt during MAC, 2 write coincident with accept
  task automatic send(input int hold, input int wmode, input int wd);
    int cyc, ey [3], es [3];
    @(negedge clk);
    in_valid = 1'b1;
    if (wmode == 2) begin
      w_we = 1'b1; w_addr = 2'd0; w_data = 8'(wd);
      wm[0] = sx(8'(wd));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    w_we = 1'b0;
    if (wmode == 1) begin
      w_we = 1'b1; w_addr = 2'd0; w_data = 8'(wd);
    end
    for (int m = 0; m < 3; m++) ey[m] = model(m, es[m]);
    cyc = 0;
    while (!ov[0] && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
      w_we = 1'b0;
    end
    chk("latency", cyc, 6);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("y_mode%0d", m), sx(yv[m]), ey[m]);
      chk($sformatf("sat_mode%0d", m), int'(sv[m]), es[m]);
    end
    repeat (hold) begin
      @(posedge clk);
      #1 chk("hold_y", sx(yv[0]), ey[0]);
      chk("hold_ready", int'(ir[0]), 0);
      chk("hold_valid", int'(ov[0]), 1);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("post_valid", int'(ov[0]), 0);
    chk("post_ready", int'(ir[0]), 1);
    chk("post_y", sx(yv[1]), ey[1]);
  endtask
  initial begin
    bit seen;
    logic [7:0] r;
    #12;
    for (int m = 0; m < 3; m++) begin
      chk("rst_valid", int'(ov[m]), 0);
      chk("rst_ready", int'(ir[m]), 1);
      chk("rst_y", sx(yv[m]), 0);
      chk("rst_sat", int'(sv[m]), 0);
    end
    @(negedge clk) rst = 1'b1;
    set_x(16, 16, 16, 16);
    send(0, 0, 0);
    chk("basic_y21", sx(yv[0]), 21);
    set_x(-16, -16, -16, -16);
    send(0, 0, 0);
    chk("neg_ident", sx(yv[1]), -31);
    chk("neg_leaky", sx(yv[2]), -4);
    set_x(40, -7, 3, 100);
    send(5, 0, 0);
    set_x(16, 16, 16, 16);
    send(0, 1, 99);
    chk("mac_write_ignored", sx(yv[0]), 21);
    send(0, 2, 0);
    chk("concurrent_write", sx(yv[0]), 16);
    for (int i = 0; i < 4; i++) wr(i, 127);
    set_x(127, 127, 127, 127);
    send(0, 0, 0);
    set_x(-128, -128, -128, -128);
    send(0, 0, 0);
    chk("sat_low", sx(yv[1]), -128);
    set_x(16, 16, 16, 16);
    @(negedge clk) in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    wm = '{5, -5, 12, 14};
    #2 chk("midrst_y", sx(yv[0]), 0);
    @(negedge clk) rst = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 seen |= ov[0];
    end
    chk("midrst_no_valid", int'(seen), 0);
    send(0, 0, 0);
    chk("after_rst_y21", sx(yv[0]), 21);
    for (int k = 0; k < 10; k++) begin
      r = 8'($urandom);
      wr(int'($urandom_range(0, 3)), sx(r));
      set_x(sx(8'($urandom)), sx(8'($urandom)), sx(8'($urandom)), sx(8'($urandom)));
      send(int'($urandom_range(0, 2)), 0, 0);
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
